// File: rtl/spi_slave_module.sv
// spi_slave_module: SPI mode-0 responder with pin synchronisers, one-entry tx holding register and byte deserialiser.
module spi_slave_module #(
  parameter logic [7:0] FILL_BYTE   = 8'h00,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       I_clk,
  input  logic       I_rst,
  input  logic       I_spi_sck,
  input  logic       I_spi_cs,
  input  logic       I_spi_mosi,
  output logic       O_spi_miso,
  output logic       O_spi_miso_oe,
  input  logic [7:0] I_tx_data,
  input  logic       I_tx_valid,
  output logic       O_tx_ready,
  output logic [7:0] O_rx_data,
  output logic       O_rx_valid,
  output logic       O_underrun,
  output logic       O_abort,
  output logic       O_busy
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sck_sync, r_cs_sync, r_mosi_sync, r_vld;
  logic r_sck_h, r_cs_h, r_armed;
  logic [7:0] r_tx_buf, r_tx_shift, r_rx_shift;
  logic r_tx_full;
  logic [2:0] r_bit_cnt;
  logic w_sck_s, w_cs_s, w_mosi_s, w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;
  logic w_start, w_stop, w_rise, w_fall, w_done, w_load, w_write;
  assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
  assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck_s & ~r_sck_h;
  assign w_sck_fall = ~w_sck_s & r_sck_h;
  assign w_cs_rise  = w_cs_s & ~r_cs_h;
  assign w_cs_fall  = ~w_cs_s & r_cs_h;
  assign w_write    = I_tx_valid & ~r_tx_full;
  assign O_tx_ready = ~r_tx_full;
  assign O_busy     = r_state == ACTIVE;
  // r_vld marks when the CS pipeline holds real pin samples, so a CS held low through reset never arms a frame
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_vld       <= '0;
      r_sck_h     <= 1'b0;
      r_cs_h      <= 1'b1;
      r_armed     <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], I_spi_sck};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], I_spi_cs};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], I_spi_mosi};
      r_vld       <= {r_vld[SYNC_STAGES-2:0], 1'b1};
      r_sck_h     <= w_sck_s;
      r_cs_h      <= w_cs_s;
      r_armed     <= r_armed | (r_vld[SYNC_STAGES-1] & w_cs_s);
    end
  end
  always_comb begin
    w_start     = (r_state == IDLE) & w_cs_fall & r_armed;
    w_stop      = (r_state == ACTIVE) & w_cs_rise;
    w_rise      = (r_state == ACTIVE) & ~w_cs_rise & w_sck_rise;
    w_fall      = (r_state == ACTIVE) & ~w_cs_rise & w_sck_fall;
    w_done      = w_rise & (r_bit_cnt == 3'd7);
    w_load      = w_start | w_done;
    w_state_nxt = w_start ? ACTIVE : w_stop ? IDLE : r_state;
  end
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      r_state       <= IDLE;
      r_tx_buf      <= '0;
      r_tx_full     <= 1'b0;
      r_tx_shift    <= '0;
      r_rx_shift    <= '0;
      r_bit_cnt     <= '0;
      O_rx_data     <= '0;
      O_rx_valid    <= 1'b0;
      O_underrun    <= 1'b0;
      O_abort       <= 1'b0;
      O_spi_miso    <= 1'b0;
      O_spi_miso_oe <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_tx_full     <= w_load ? w_write : (r_tx_full | w_write);
      r_tx_buf      <= w_write ? I_tx_data : r_tx_buf;
      r_tx_shift    <= w_load ? (r_tx_full ? r_tx_buf : FILL_BYTE) :
                       w_stop ? 8'h00 :
                       (w_fall && r_bit_cnt != 3'd0) ? {r_tx_shift[6:0], 1'b0} : r_tx_shift;
      r_rx_shift    <= w_stop ? 8'h00 : w_rise ? {r_rx_shift[6:0], w_mosi_s} : r_rx_shift;
      r_bit_cnt     <= (w_start | w_stop) ? 3'd0 : w_rise ? r_bit_cnt + 3'd1 : r_bit_cnt;
      O_rx_data     <= w_done ? {r_rx_shift[6:0], w_mosi_s} : O_rx_data;
      O_rx_valid    <= w_done;
      O_underrun    <= w_load & ~r_tx_full;
      O_abort       <= w_stop & (r_bit_cnt != 3'd0);
      O_spi_miso    <= (r_state == ACTIVE) & ~w_stop & r_tx_shift[7];
      O_spi_miso_oe <= w_state_nxt == ACTIVE;
    end
  end
endmodule
